// File: rtl/pulse_sweep_sequencer.sv
// Duty-cycle sweep sequencer for the pulse mask: holds the divider fixed and steps duty
// between start and stop, dwelling a programmed number of mask periods at each value.
module pulse_sweep_sequencer #(
    parameter int CNT_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               trigger,
    input  logic               single_shot,
    input  logic               bidir,
    input  logic [CNT_W-1:0]   divider_in,
    input  logic [CNT_W-1:0]   duty_start,
    input  logic [CNT_W-1:0]   duty_stop,
    input  logic [CNT_W-1:0]   duty_step,
    input  logic [DWELL_W-1:0] dwell_periods,
    output logic [CNT_W-1:0]   divider_out,
    output logic [CNT_W-1:0]   duty_out,
    output logic               busy,
    output logic               step_strobe,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic [CNT_W-1:0]   div_r, start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               single_r, bidir_r;
    logic               dir_down_r, dir_down_s;
    logic [CNT_W-1:0]   period_r, period_s;
    logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_s;
    logic [CNT_W-1:0]   divider_s, duty_s;
    logic               busy_s, step_strobe_s, done_s, cfg_err_s, load_s;

    logic [CNT_W:0]     up_nxt_s, start_plus_s;
    logic [CNT_W-1:0]   down_val_s, rise_val_s;
    logic               cfg_ok_s, top_hit_s, bottom_hit_s, period_wrap_s, dwell_last_s;

    // Duty arithmetic is one bit wider than the operands so sums near full scale cannot wrap.
    assign up_nxt_s      = {1'b0, duty_out} + {1'b0, step_r};
    assign start_plus_s  = {1'b0, start_r} + {1'b0, step_r};
    assign top_hit_s     = up_nxt_s > {1'b0, stop_r};
    assign bottom_hit_s  = {1'b0, duty_out} < start_plus_s;
    assign down_val_s    = bottom_hit_s ? start_r : (duty_out - step_r);
    assign rise_val_s    = (start_plus_s > {1'b0, stop_r}) ? stop_r : start_plus_s[CNT_W-1:0];
    assign period_wrap_s = (period_r == (div_r - CNT_W'(1)));
    assign dwell_last_s  = (dwell_cnt_r == (dwell_r - DWELL_W'(1)));

    assign cfg_ok_s = (divider_in != {CNT_W{1'b0}}) &&
                      (duty_step != {CNT_W{1'b0}}) &&
                      (dwell_periods != {DWELL_W{1'b0}}) &&
                      (duty_start != {CNT_W{1'b0}}) &&
                      (duty_start <= duty_stop) &&
                      (duty_stop <= divider_in);

    // Next-state, counter and output computation.
    always_comb begin
        state_s       = state_r;
        dir_down_s    = dir_down_r;
        period_s      = period_r;
        dwell_cnt_s   = dwell_cnt_r;
        divider_s     = divider_out;
        duty_s        = duty_out;
        busy_s        = busy;
        step_strobe_s = 1'b0;
        done_s        = 1'b0;
        cfg_err_s     = 1'b0;
        load_s        = 1'b0;

        case (state_r)
            IDLE: begin
                divider_s   = {CNT_W{1'b0}};
                duty_s      = {CNT_W{1'b0}};
                busy_s      = 1'b0;
                dir_down_s  = 1'b0;
                period_s    = {CNT_W{1'b0}};
                dwell_cnt_s = {DWELL_W{1'b0}};
                if (trigger && enable) begin
                    if (cfg_ok_s) begin
                        state_s   = RUN;
                        load_s    = 1'b1;
                        divider_s = divider_in;
                        duty_s    = duty_start;
                        busy_s    = 1'b1;
                    end else begin
                        cfg_err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_s     = IDLE;
                    divider_s   = {CNT_W{1'b0}};
                    duty_s      = {CNT_W{1'b0}};
                    busy_s      = 1'b0;
                    dir_down_s  = 1'b0;
                    period_s    = {CNT_W{1'b0}};
                    dwell_cnt_s = {DWELL_W{1'b0}};
                end else if (period_wrap_s) begin
                    period_s = {CNT_W{1'b0}};
                    if (dwell_last_s) begin
                        dwell_cnt_s = {DWELL_W{1'b0}};
                        if (!dir_down_r) begin
                            if (top_hit_s) begin
                                if (single_r) begin
                                    state_s   = DONE;
                                    divider_s = {CNT_W{1'b0}};
                                    duty_s    = {CNT_W{1'b0}};
                                    busy_s    = 1'b0;
                                    done_s    = 1'b1;
                                end else if (bidir_r) begin
                                    dir_down_s    = 1'b1;
                                    duty_s        = down_val_s;
                                    step_strobe_s = 1'b1;
                                end else begin
                                    duty_s        = start_r;
                                    step_strobe_s = 1'b1;
                                end
                            end else begin
                                duty_s        = up_nxt_s[CNT_W-1:0];
                                step_strobe_s = 1'b1;
                            end
                        end else begin
                            // Going down: bottom turns around to start+step, else keep descending.
                            dir_down_s    = !bottom_hit_s;
                            duty_s        = bottom_hit_s ? rise_val_s : down_val_s;
                            step_strobe_s = 1'b1;
                        end
                    end else begin
                        dwell_cnt_s = dwell_cnt_r + DWELL_W'(1);
                    end
                end else begin
                    period_s = period_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s     = IDLE;
                divider_s   = {CNT_W{1'b0}};
                duty_s      = {CNT_W{1'b0}};
                busy_s      = 1'b0;
                dir_down_s  = 1'b0;
                period_s    = {CNT_W{1'b0}};
                dwell_cnt_s = {DWELL_W{1'b0}};
            end
            default: begin
                state_s     = IDLE;
                divider_s   = {CNT_W{1'b0}};
                duty_s      = {CNT_W{1'b0}};
                busy_s      = 1'b0;
                dir_down_s  = 1'b0;
                period_s    = {CNT_W{1'b0}};
                dwell_cnt_s = {DWELL_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            dir_down_r  <= 1'b0;
            period_r    <= {CNT_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            divider_out <= {CNT_W{1'b0}};
            duty_out    <= {CNT_W{1'b0}};
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_r     <= state_s;
            dir_down_r  <= dir_down_s;
            period_r    <= period_s;
            dwell_cnt_r <= dwell_cnt_s;
            divider_out <= divider_s;
            duty_out    <= duty_s;
            busy        <= busy_s;
            step_strobe <= step_strobe_s;
            done        <= done_s;
            cfg_err     <= cfg_err_s;
        end
    end

    // Shadow copy of the configuration, captured only on entry to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r    <= {CNT_W{1'b0}};
            start_r  <= {CNT_W{1'b0}};
            stop_r   <= {CNT_W{1'b0}};
            step_r   <= {CNT_W{1'b0}};
            dwell_r  <= {DWELL_W{1'b0}};
            single_r <= 1'b0;
            bidir_r  <= 1'b0;
        end else if (load_s) begin
            div_r    <= divider_in;
            start_r  <= duty_start;
            stop_r   <= duty_stop;
            step_r   <= duty_step;
            dwell_r  <= dwell_periods;
            single_r <= single_shot;
            bidir_r  <= bidir;
        end else begin
            div_r    <= div_r;
            start_r  <= start_r;
            stop_r   <= stop_r;
            step_r   <= step_r;
            dwell_r  <= dwell_r;
            single_r <= single_r;
            bidir_r  <= bidir_r;
        end
    end

endmodule

// File: tb/tb_pulse_sweep_sequencer.sv
// Self-checking bench for pulse_sweep_sequencer: directed sweeps plus randomized configs,
// each checked cycle by cycle against a step-list model of the sweep.
module tb_pulse_sweep_sequencer;

    localparam int CW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset, enable, trigger, single_shot, bidir;
    logic [CW-1:0] divider_in, duty_start, duty_stop, duty_step;
    logic [DW-1:0] dwell_periods;
    logic [CW-1:0] divider_out, duty_out;
    logic          busy, step_strobe, done, cfg_err;

    int vectors     = 0;
    int miscompares = 0;
    longint exp_seq[$];
    bit     exp_ends;

    pulse_sweep_sequencer #(.CNT_W(CW), .DWELL_W(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .single_shot(single_shot), .bidir(bidir), .divider_in(divider_in),
        .duty_start(duty_start), .duty_stop(duty_stop), .duty_step(duty_step),
        .dwell_periods(dwell_periods), .divider_out(divider_out), .duty_out(duty_out),
        .busy(busy), .step_strobe(step_strobe), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_duty"}, 64'(duty_out), 64'd0);
        chk({tag, "_div"}, 64'(divider_out), 64'd0);
    endtask

    // List of duty values visited, one per dwell, derived from the sweep rules.
    task automatic build_model(input longint st, input longint sp, input longint stp,
                               input bit ss, input bit bd, input int maxn);
        longint d;
        bit     up;
        exp_seq.delete();
        exp_ends = 1'b0;
        d  = st;
        up = 1'b1;
        exp_seq.push_back(d);
        while (exp_seq.size() < maxn) begin
            if (up) begin
                if (d + stp > sp) begin
                    if (ss) begin
                        exp_ends = 1'b1;
                        break;
                    end else if (bd) begin
                        up = 1'b0;
                        d  = (d - stp < st) ? st : d - stp;
                    end else begin
                        d = st;
                    end
                end else begin
                    d = d + stp;
                end
            end else begin
                if (d < st + stp) begin
                    up = 1'b1;
                    d  = (st + stp > sp) ? sp : st + stp;
                end else begin
                    d = d - stp;
                end
            end
            exp_seq.push_back(d);
        end
    endtask

    // Trigger with the current inputs, then check ncyc cycles against the model.
    task automatic run_check(input string tag, input int ncyc, input int abort_k,
                             input bit scramble, input bit trig_in_done);
        longint dv, P, idx, rem;
        longint e_duty, e_div;
        bit     e_busy, e_str, e_done;
        dv = longint'(divider_in);
        P  = dv * longint'(dwell_periods);
        build_model(longint'(duty_start), longint'(duty_stop), longint'(duty_step),
                    single_shot, bidir, int'(ncyc / P) + 2);
        enable  = 1'b1;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            idx = (k - 1) / P;
            rem = (k - 1) % P;
            e_duty = 0; e_div = 0; e_busy = 0; e_str = 0; e_done = 0;
            if (abort_k != 0 && k > abort_k) begin
                e_busy = 0;
            end else if (idx < exp_seq.size()) begin
                e_busy = 1;
                e_duty = exp_seq[idx];
                e_div  = dv;
                e_str  = (k > 1) && (rem == 0);
            end else if (exp_ends && idx == exp_seq.size() && rem == 0) begin
                e_done = 1;
            end
            chk({tag, "_duty"}, 64'(duty_out), e_duty);
            chk({tag, "_div"}, 64'(divider_out), e_div);
            chk({tag, "_busy"}, 64'(busy), 64'(e_busy));
            chk({tag, "_strobe"}, 64'(step_strobe), 64'(e_str));
            chk({tag, "_done"}, 64'(done), 64'(e_done));
            chk({tag, "_cfgerr"}, 64'(cfg_err), 64'd0);
            if (scramble && k == 7) begin
                duty_stop     = CW'($urandom);
                duty_start    = CW'($urandom);
                divider_in    = CW'($urandom);
                duty_step     = CW'($urandom);
                dwell_periods = DW'($urandom);
                single_shot   = ~single_shot;
                bidir         = ~bidir;
            end
            if (k == abort_k) enable = 1'b0;
            if (trig_in_done && e_done) trigger = 1'b1;
            tick();
            trigger = 1'b0;
        end
        enable = 1'b0;
        tick();
        chk_idle({tag, "_end"});
        enable = 1'b1;
    endtask

    task automatic set_cfg(input int dv, input int st, input int sp, input int stp,
                           input int dw, input bit ss, input bit bd);
        divider_in    = CW'(dv);
        duty_start    = CW'(st);
        duty_stop     = CW'(sp);
        duty_step     = CW'(stp);
        dwell_periods = DW'(dw);
        single_shot   = ss;
        bidir         = bd;
    endtask

    initial begin
        int  dv, st, sp, stp, dw;
        bit  en, valid;

        // Reset, with a valid trigger held alongside it.
        reset   = 1'b1;
        enable  = 1'b1;
        trigger = 1'b1;
        set_cfg(10, 2, 6, 2, 3, 1'b1, 1'b0);
        tick();
        tick();
        chk_idle("reset");
        chk("reset_strobe", 64'(step_strobe), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cfgerr", 64'(cfg_err), 64'd0);
        reset   = 1'b0;
        trigger = 1'b0;
        tick();
        chk_idle("post_reset");

        // Single sweep, with a trigger presented during DONE.
        set_cfg(10, 2, 6, 2, 3, 1'b1, 1'b0);
        run_check("single", 95, 0, 1'b0, 1'b1);

        // Sawtooth and triangle.
        set_cfg(10, 2, 6, 2, 3, 1'b0, 1'b0);
        run_check("sawtooth", 155, 0, 1'b0, 1'b0);
        set_cfg(10, 2, 7, 2, 3, 1'b0, 1'b1);
        run_check("triangle", 185, 0, 1'b0, 1'b0);

        // Top-of-range sweep: the sum past full scale must end the sweep, not wrap.
        set_cfg(12'hFFF, 12'hFE0, 12'hFFF, 12'h010, 1, 1'b1, 1'b0);
        run_check("overflow", 2 * 4095 + 3, 0, 1'b0, 1'b0);

        // Rejected configurations.
        set_cfg(10, 2, 6, 0, 3, 1'b1, 1'b0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("rej_step_err", 64'(cfg_err), 64'd1);
        chk("rej_step_busy", 64'(busy), 64'd0);
        tick();
        chk("rej_step_clr", 64'(cfg_err), 64'd0);
        set_cfg(10, 2, 11, 2, 3, 1'b1, 1'b0);
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("rej_stop_err", 64'(cfg_err), 64'd1);
        chk("rej_stop_busy", 64'(busy), 64'd0);
        tick();

        // Shadowing: inputs scrambled mid-run must not disturb the sweep.
        set_cfg(4, 1, 4, 1, 2, 1'b1, 1'b0);
        run_check("shadow", 40, 0, 1'b1, 1'b0);

        // Abort at cycle 45, then a fresh restart.
        set_cfg(10, 2, 6, 2, 3, 1'b1, 1'b0);
        run_check("abort", 49, 45, 1'b0, 1'b0);
        run_check("restart", 95, 0, 1'b0, 1'b0);

        // Randomized configurations, including invalid ones and disabled triggers.
        for (int it = 0; it < 40; it++) begin
            dv  = $urandom_range(0, 6);
            st  = $urandom_range(0, 6);
            sp  = $urandom_range(0, 6);
            stp = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            en  = ($urandom_range(0, 5) != 0);
            set_cfg(dv, st, sp, stp, dw, 1'($urandom), 1'($urandom));
            valid = (dv != 0) && (stp != 0) && (dw != 0) && (st != 0) && (st <= sp) && (sp <= dv);
            if (en && valid) begin
                run_check("rand_run", 70, 0, 1'b0, 1'b0);
            end else begin
                enable  = en;
                trigger = 1'b1;
                tick();
                trigger = 1'b0;
                chk("rand_cfgerr", 64'(cfg_err), 64'(en));
                chk("rand_busy", 64'(busy), 64'd0);
                enable = 1'b1;
                tick();
                chk("rand_cfgerr_clr", 64'(cfg_err), 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
